// File: rtl/prefix_result_collector.sv
// Result collector behind the pipelined prefix adder. It tags the adder slots that carry real work,
// captures {cout,s} into an in-order FWFT FIFO and issues credits so no result is dropped.
module prefix_result_collector #(
  parameter int WIDTH = 32,
  parameter int LAT   = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           sum_in,
  input  logic                       cout_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_sum,
  output logic                       out_cout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LAT + 1);
  localparam int SW = $clog2(DEPTH + LAT + 1);

  logic [LAT-1:0]  vpipe_q, vpipe_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [WIDTH:0]  mem_q [DEPTH];

  logic [IW-1:0]   inflight;
  logic [SW-1:0]   occupancy;
  logic            issue, push, pop, full, wr_en;
  logic [WIDTH:0]  head;

  // Credits count results already stored plus those still inside the adder, so the
  // FIFO always has room for everything the adder will deliver.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < LAT; i++) begin
      inflight = inflight + IW'(vpipe_q[i]);
    end
    occupancy = SW'(count_q) + SW'(inflight);
    in_ready  = occupancy < SW'(DEPTH);
  end

  assign issue = in_valid & in_ready;
  assign push  = vpipe_q[LAT-1];
  assign full  = count_q == CW'(DEPTH);
  assign pop   = out_valid & out_ready;
  assign wr_en = push & (~full | pop);

  always_comb begin
    vpipe_d    = '0;
    vpipe_d[0] = issue;
    for (int unsigned i = 1; i < LAT; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (push && full && !pop) begin
      ovf_d = 1'b1;
    end
    if (wr_en && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !wr_en) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      vpipe_q  <= vpipe_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: validity is carried entirely by count_q.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {cout_in, sum_in};
    end
  end

  assign out_valid    = count_q != '0;
  assign head         = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_sum      = head[WIDTH-1:0];
  assign out_cout     = head[WIDTH];
  assign count        = count_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_prefix_result_collector.sv
// Bench for prefix_result_collector: a behavioural adder feeds the DUT, and a transaction-level
// model (timestamped in-flight list plus result queue) predicts every output each cycle.
module tb_prefix_result_collector;

  localparam int WIDTH = 32;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  sum_in;
  logic              cout_in;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_sum;
  logic              out_cout;
  logic [3:0]        count;
  logic              overflow_err;

  logic [31:0] xa = '0, ya = '0;
  logic        ca = 1'b0;

  prefix_result_collector #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .cout_in(cout_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .count(count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Stand-in for the adder: never stalls, never resets, result appears LAT-1 edges after sampling.
  logic [32:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, xa} + {1'b0, ya} + 33'(ca);
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign sum_in  = apipe[LAT-1][31:0];
  assign cout_in = apipe[LAT-1][32];

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  logic [32:0] mq[$];
  int unsigned fl_due[$];
  logic [32:0] fl_val[$];
  logic        m_ovf = 1'b0;
  int unsigned edge_n = 0;
  logic [32:0] obs[$];
  int unsigned dut_accepts = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        c;
    logic [31:0] es;
    logic        ec;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare against the model, advance the model past the posedge.
  task automatic cycle(input logic iv, input logic [31:0] x, input logic [31:0] y,
                       input logic c, input logic ordy);
    logic        exp_rdy, do_issue, do_pop;
    logic [32:0] hd;
    in_valid = iv; xa = x; ya = y; ca = c; out_ready = ordy;
    #1;
    exp_rdy = (mq.size() + fl_due.size()) < DEPTH;
    hd = (mq.size() != 0) ? mq[0] : '0;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("out_sum", 64'(out_sum), 64'(hd[31:0]));
    chk("out_cout", 64'(out_cout), 64'(hd[32]));
    chk("count", 64'(count), 64'(mq.size()));
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
    do_issue = iv & exp_rdy;
    do_pop   = (mq.size() != 0) & ordy;
    if (out_valid === 1'b1 && ordy) obs.push_back({out_cout, out_sum});
    if (iv && in_ready === 1'b1) dut_accepts++;
    @(posedge clk);
    edge_n++;
    if (do_pop) void'(mq.pop_front());
    while (fl_due.size() != 0 && fl_due[0] == edge_n) begin
      if (mq.size() >= DEPTH) m_ovf = 1'b1;
      else mq.push_back(fl_val[0]);
      void'(fl_due.pop_front());
      void'(fl_val.pop_front());
    end
    if (do_issue) begin
      fl_due.push_back(edge_n + LAT);
      fl_val.push_back({1'b0, x} + {1'b0, y} + 33'(c));
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, $urandom, 1'(($urandom)), ordy);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst in_ready", 64'(in_ready), 64'(1));
    chk("rst count", 64'(count), 64'(0));
    chk("rst overflow_err", 64'(overflow_err), 64'(0));
    chk("rst out_sum", 64'(out_sum), 64'(0));
    chk("rst out_cout", 64'(out_cout), 64'(0));
    mq.delete(); fl_due.delete(); fl_val.delete(); m_ovf = 1'b0;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_obs(input string nm, input int lo, input int hi);
    chk({nm, " result count"}, 64'(obs.size()), 64'(hi - lo + 1));
    for (int i = lo; i <= hi; i++) begin
      if (i - lo < obs.size()) chk(nm, 64'(obs[i-lo]), 64'({tbl[i].ec, tbl[i].es}));
    end
  endtask

  initial begin
    int lat_n;
    tbl[0] = '{32'd15, 32'd35, 1'b1, 32'd51,  1'b0};
    tbl[1] = '{32'd24, 32'd43, 1'b1, 32'd68,  1'b0};
    tbl[2] = '{32'd53, 32'd70, 1'b1, 32'd124, 1'b0};
    tbl[3] = '{32'd51, 32'd9,  1'b0, 32'd60,  1'b0};
    tbl[4] = '{32'd72, 32'd91, 1'b0, 32'd163, 1'b0};
    tbl[5] = '{32'd18, 32'd37, 1'b1, 32'd56,  1'b0};
    tbl[6] = '{32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0, 1'b1};

    @(negedge clk);
    do_reset();
    idle(2, 1'b1);

    // Single transaction: out_valid appears after exactly LAT edges following the issue edge.
    obs.delete();
    cycle(1'b1, tbl[0].x, tbl[0].y, tbl[0].c, 1'b1);
    lat_n = 0;
    while (out_valid !== 1'b1 && lat_n < 20) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      lat_n++;
    end
    chk("single latency", 64'(lat_n), 64'(LAT));
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    chk("single out_valid falls", 64'(out_valid), 64'(0));
    check_obs("single", 0, 0);

    // Back-to-back stream from the table.
    obs.delete();
    for (int i = 0; i <= 5; i++) cycle(1'b1, tbl[i].x, tbl[i].y, tbl[i].c, 1'b1);
    idle(10, 1'b1);
    check_obs("stream", 0, 5);

    obs.delete();
    cycle(1'b1, tbl[6].x, tbl[6].y, tbl[6].c, 1'b1);
    idle(8, 1'b1);
    check_obs("carry", 6, 6);

    // Backpressure: credits cap accepted issues at DEPTH.
    dut_accepts = 0;
    for (int i = 0; i < 12; i++) cycle(1'b1, $urandom, $urandom, 1'($urandom), 1'b0);
    idle(LAT + 2, 1'b0);
    chk("bp accepts", 64'(dut_accepts), 64'(DEPTH));
    chk("bp count", 64'(count), 64'(DEPTH));
    chk("bp in_ready", 64'(in_ready), 64'(0));
    idle(DEPTH + 2, 1'b1);
    chk("bp drained in_ready", 64'(in_ready), 64'(1));
    chk("bp drained count", 64'(count), 64'(0));

    // Random traffic with random consumer stalls; pointers wrap many times.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom),
            1'($urandom_range(0, 2) != 0));
    idle(LAT + DEPTH + 4, 1'b1);
    chk("random drained count", 64'(count), 64'(0));

    // Reset with results in flight: stale adder outputs must not be captured.
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0);
    idle(2, 1'b0);
    do_reset();
    obs.delete();
    idle(10, 1'b1);
    chk("mid-flight results after reset", 64'(obs.size()), 64'(0));
    chk("mid-flight count", 64'(count), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
